// File: rtl/hdlc_rx_deframer.sv
// Receive-side HDLC bit deframer: flag hunt, zero destuffing, abort detection
// and LSB-first octet assembly with frame start/end/length/error markers.
module hdlc_rx_deframer #(
    parameter int unsigned FRAME_LEN_W     = 8,
    parameter int unsigned MIN_FRAME_BYTES = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   rxen_i,
    input  logic                   rx_bit_en_i,
    input  logic                   rx_i,
    output logic [7:0]             byte_o,
    output logic                   byte_valid_o,
    output logic                   sof_o,
    output logic                   eof_o,
    output logic                   frame_err_o,
    output logic [FRAME_LEN_W-1:0] frame_len_o,
    output logic                   abort_o,
    output logic                   active_o
);

    localparam int unsigned DLY_W = 7;
    localparam logic [FRAME_LEN_W-1:0] CNT_MAX = '1;
    localparam logic [FRAME_LEN_W-1:0] CNT_MIN = FRAME_LEN_W'(MIN_FRAME_BYTES);
    localparam logic [FRAME_LEN_W-1:0] CNT_ONE = FRAME_LEN_W'(1);

    typedef enum logic [1:0] {HUNT, FLAG_SEEN, DATA} state_t;

    state_t                 state_q, state_d;
    logic [2:0]             ones_q, ones_d;
    logic [DLY_W-1:0]       dly_q, dly_d;
    logic [2:0]             dly_cnt_q, dly_cnt_d;
    logic [7:0]             asm_q, asm_d;
    logic [2:0]             idx_q, idx_d;
    logic [FRAME_LEN_W-1:0] cnt_q, cnt_d;
    logic [7:0]             byte_q, byte_d;
    logic [FRAME_LEN_W-1:0] len_q, len_d;
    logic                   byte_valid_q, byte_valid_d;
    logic                   sof_q, sof_d;
    logic                   eof_q, eof_d;
    logic                   err_q, err_d;
    logic                   abort_q, abort_d;
    logic                   active_q, active_d;

    // Line-bit classification, always against the ones count before this bit
    logic strobe, ev_stuff, ev_flag, ev_abort, ev_data, pop;
    assign strobe   = rxen_i & rx_bit_en_i;
    assign ev_stuff = strobe & ~rx_i & (ones_q == 3'd5);
    assign ev_flag  = strobe & ~rx_i & (ones_q == 3'd6);
    assign ev_abort = strobe &  rx_i & (ones_q == 3'd6);
    assign ev_data  = strobe & ~ev_stuff & ~ev_flag & ~ev_abort;
    assign pop      = ev_data & (dly_cnt_q == 3'(DLY_W));

    always_comb begin
        state_d      = state_q;
        ones_d       = ones_q;
        dly_d        = dly_q;
        dly_cnt_d    = dly_cnt_q;
        asm_d        = asm_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        byte_d       = byte_q;
        len_d        = len_q;
        byte_valid_d = 1'b0;
        sof_d        = 1'b0;
        eof_d        = 1'b0;
        err_d        = 1'b0;
        abort_d      = 1'b0;

        if (!rxen_i) begin
            state_d   = HUNT;
            ones_d    = '0;
            dly_d     = '0;
            dly_cnt_d = '0;
            asm_d     = '0;
            idx_d     = '0;
            cnt_d     = '0;
            abort_d   = (state_q == DATA);
        end else if (strobe) begin
            if (rx_i) begin
                ones_d = (ones_q == 3'd7) ? 3'd7 : ones_q + 3'd1;
            end else begin
                ones_d = '0;
            end

            // Delay line keeps the flag's leading 0111111 away from the assembler
            if (ev_data && state_q != HUNT) begin
                dly_d = {rx_i, dly_q[DLY_W-1:1]};
                if (!pop) begin
                    dly_cnt_d = dly_cnt_q + 3'd1;
                end
            end

            unique case (state_q)
                HUNT: begin
                    if (ev_flag) begin
                        state_d   = FLAG_SEEN;
                        dly_d     = '0;
                        dly_cnt_d = '0;
                        asm_d     = '0;
                        idx_d     = '0;
                    end
                end
                FLAG_SEEN: begin
                    if (ev_flag) begin
                        dly_d     = '0;
                        dly_cnt_d = '0;
                    end else if (ev_abort) begin
                        state_d = HUNT;
                    end else if (pop) begin
                        state_d = DATA;
                        cnt_d   = '0;
                        asm_d   = {dly_q[0], 7'd0};
                        idx_d   = 3'd1;
                    end
                end
                DATA: begin
                    if (ev_flag) begin
                        state_d   = FLAG_SEEN;
                        eof_d     = 1'b1;
                        len_d     = cnt_q;
                        err_d     = (idx_q != 3'd0) || (cnt_q < CNT_MIN) || (cnt_q == CNT_MAX);
                        dly_d     = '0;
                        dly_cnt_d = '0;
                        asm_d     = '0;
                        idx_d     = '0;
                    end else if (ev_abort) begin
                        state_d   = HUNT;
                        abort_d   = 1'b1;
                        dly_d     = '0;
                        dly_cnt_d = '0;
                        asm_d     = '0;
                        idx_d     = '0;
                    end else if (pop) begin
                        asm_d = {dly_q[0], asm_q[7:1]};
                        idx_d = idx_q + 3'd1;
                        if (idx_q == 3'd7) begin
                            byte_d       = {dly_q[0], asm_q[7:1]};
                            byte_valid_d = 1'b1;
                            sof_d        = (cnt_q == '0);
                            if (cnt_q != CNT_MAX) begin
                                cnt_d = cnt_q + CNT_ONE;
                            end
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end

        active_d = (state_d == DATA);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q      <= HUNT;
            ones_q       <= '0;
            dly_q        <= '0;
            dly_cnt_q    <= '0;
            asm_q        <= '0;
            idx_q        <= '0;
            cnt_q        <= '0;
            byte_q       <= '0;
            len_q        <= '0;
            byte_valid_q <= 1'b0;
            sof_q        <= 1'b0;
            eof_q        <= 1'b0;
            err_q        <= 1'b0;
            abort_q      <= 1'b0;
            active_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            ones_q       <= ones_d;
            dly_q        <= dly_d;
            dly_cnt_q    <= dly_cnt_d;
            asm_q        <= asm_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            byte_q       <= byte_d;
            len_q        <= len_d;
            byte_valid_q <= byte_valid_d;
            sof_q        <= sof_d;
            eof_q        <= eof_d;
            err_q        <= err_d;
            abort_q      <= abort_d;
            active_q     <= active_d;
        end
    end

    assign byte_o       = byte_q;
    assign byte_valid_o = byte_valid_q;
    assign sof_o        = sof_q;
    assign eof_o        = eof_q;
    assign frame_err_o  = err_q;
    assign frame_len_o  = len_q;
    assign abort_o      = abort_q;
    assign active_o     = active_q;

endmodule

// File: tb/tb_hdlc_rx_deframer.sv
// Bench for hdlc_rx_deframer: bit-stuffing line driver, frame vector table and
// hand sequences for abort, enable drop, reset, shared flags and length saturation.
module tb_hdlc_rx_deframer;

    localparam int unsigned FLW = 8;

    logic           clk_i = 1'b0;
    logic           rst_n_i;
    logic           rxen_i;
    logic           rx_bit_en_i;
    logic           rx_i;
    logic [7:0]     byte_o;
    logic           byte_valid_o;
    logic           sof_o;
    logic           eof_o;
    logic           frame_err_o;
    logic [FLW-1:0] frame_len_o;
    logic           abort_o;
    logic           active_o;

    always #5 clk_i = ~clk_i;

    hdlc_rx_deframer #(.FRAME_LEN_W(FLW), .MIN_FRAME_BYTES(4)) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .rxen_i       (rxen_i),
        .rx_bit_en_i  (rx_bit_en_i),
        .rx_i         (rx_i),
        .byte_o       (byte_o),
        .byte_valid_o (byte_valid_o),
        .sof_o        (sof_o),
        .eof_o        (eof_o),
        .frame_err_o  (frame_err_o),
        .frame_len_o  (frame_len_o),
        .abort_o      (abort_o),
        .active_o     (active_o)
    );

    typedef struct {
        int          nbytes;
        logic [47:0] data;
        int          xbits;
        logic [7:0]  xval;
        int          gap;
        int          exp_eof;
        int          exp_len;
        int          exp_err;
    } vec_t;

    vec_t vecs[7];

    int checks = 0;
    int failures = 0;
    int ones_tx = 0;
    int gap_mode = 0;
    int bit_no = 0;

    logic [7:0] got_bytes[$];
    int         got_len[$];
    int         got_err[$];
    int         n_sof, n_eof, n_abort, n_bad;
    int         sof_byte;

    // Output monitor, sampled away from the active edge
    always @(negedge clk_i) begin
        if (byte_valid_o) got_bytes.push_back(byte_o);
        if (sof_o) begin
            n_sof++;
            sof_byte = int'(byte_o);
            if (!byte_valid_o) n_bad++;
        end
        if (eof_o) begin
            n_eof++;
            got_len.push_back(int'(frame_len_o));
            got_err.push_back(int'(frame_err_o));
            if (byte_valid_o) n_bad++;
        end
        if (abort_o) n_abort++;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clr_mon();
        got_bytes.delete();
        got_len.delete();
        got_err.delete();
        n_sof = 0; n_eof = 0; n_abort = 0; n_bad = 0; sof_byte = -1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk_i); #1; end
    endtask

    task automatic send_bit(input logic b);
        rx_i = b;
        rx_bit_en_i = 1'b1;
        @(posedge clk_i); #1;
        rx_bit_en_i = 1'b0;
        bit_no++;
        if (gap_mode != 0 && (bit_no % 3) == 0) idle(1);
    endtask

    // Transmitter-side zero insertion after five consecutive ones
    task automatic send_dbit(input logic b);
        send_bit(b);
        if (b) begin
            ones_tx++;
            if (ones_tx == 5) begin
                send_bit(1'b0);
                ones_tx = 0;
            end
        end else begin
            ones_tx = 0;
        end
    endtask

    task automatic send_flag();
        logic [7:0] f;
        f = 8'h7E;
        for (int i = 0; i < 8; i++) send_bit(f[i]);
        ones_tx = 0;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int k = 0; k < 8; k++) send_dbit(v[k]);
    endtask

    task automatic send_bytes(input logic [47:0] d, input int n);
        for (int i = 0; i < n; i++) send_byte(d[8*i +: 8]);
    endtask

    task automatic send_frame(input logic [47:0] d, input int n);
        send_flag();
        send_bytes(d, n);
        send_flag();
        idle(2);
    endtask

    task automatic check_frame(input string tag, input logic [47:0] d, input int n,
                               input int exp_eof, input int exp_len, input int exp_err);
        chk({tag, " nbytes"}, got_bytes.size(), n);
        for (int i = 0; i < n && i < got_bytes.size(); i++)
            chk($sformatf("%s byte%0d", tag, i), int'(got_bytes[i]), int'(d[8*i +: 8]));
        chk({tag, " sof_count"}, n_sof, (n > 0) ? 1 : 0);
        if (n > 0) chk({tag, " sof_byte"}, sof_byte, int'(d[7:0]));
        chk({tag, " eof_count"}, n_eof, exp_eof);
        if (exp_eof != 0) begin
            chk({tag, " frame_len"}, (got_len.size() > 0) ? got_len[0] : -1, exp_len);
            chk({tag, " frame_err"}, (got_err.size() > 0) ? got_err[0] : -1, exp_err);
        end
        chk({tag, " abort_count"}, n_abort, 0);
        chk({tag, " pulse_overlap"}, n_bad, 0);
    endtask

    initial begin
        vecs[0] = '{4, 48'h0000_FF01_3CA5, 0, 8'h00, 0, 1, 4, 0};
        vecs[1] = '{4, 48'h0000_FFFF_7E7E, 0, 8'h00, 0, 1, 4, 0};
        vecs[2] = '{1, 48'h0000_0000_0055, 3, 8'h05, 1, 1, 1, 1};
        vecs[3] = '{2, 48'h0000_0000_2211, 0, 8'h00, 0, 1, 2, 1};
        vecs[4] = '{3, 48'h0000_00CC_BBAA, 0, 8'h00, 0, 1, 3, 1};
        vecs[5] = '{5, 48'h0005_0403_0201, 0, 8'h00, 1, 1, 5, 0};
        vecs[6] = '{0, 48'h0000_0000_0000, 0, 8'h00, 0, 0, 0, 0};

        rst_n_i = 1'b0; rxen_i = 1'b1; rx_bit_en_i = 1'b0; rx_i = 1'b0;
        clr_mon();
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("reset_outputs", int'({byte_o, frame_len_o, byte_valid_o, sof_o, eof_o,
                                   frame_err_o, abort_o, active_o}), 0);
        @(posedge clk_i); #1;
        rst_n_i = 1'b1;
        idle(2);

        for (int v = 0; v < 7; v++) begin
            clr_mon();
            gap_mode = vecs[v].gap;
            send_flag();
            send_bytes(vecs[v].data, vecs[v].nbytes);
            for (int k = 0; k < vecs[v].xbits; k++) send_dbit(vecs[v].xval[k]);
            send_flag();
            idle(2);
            gap_mode = 0;
            check_frame($sformatf("vec%0d", v), vecs[v].data, vecs[v].nbytes,
                        vecs[v].exp_eof, vecs[v].exp_len, vecs[v].exp_err);
        end

        // Idle all-ones line after a closing flag: silent fall back to hunt
        clr_mon();
        for (int i = 0; i < 20; i++) send_bit(1'b1);
        idle(2);
        chk("idle_ones pulses", n_sof + n_eof + n_abort + got_bytes.size(), 0);
        chk("idle_ones active", int'(active_o), 0);

        // Abort after three octets; the last octet is still inside the delay line
        clr_mon();
        send_flag();
        send_bytes(48'h0000_0000_3412, 2);
        chk("abort active_mid", int'(active_o), 1);
        send_byte(8'h56);
        for (int i = 0; i < 7; i++) send_bit(1'b1);
        ones_tx = 0;
        idle(2);
        chk("abort count", n_abort, 1);
        chk("abort eof", n_eof, 0);
        chk("abort active", int'(active_o), 0);
        chk("abort nbytes", got_bytes.size(), 2);
        clr_mon();
        send_frame(48'h0000_DDCC_BBAA, 4);
        check_frame("post_abort", 48'h0000_DDCC_BBAA, 4, 1, 4, 0);

        // Shared flags between back-to-back frames
        clr_mon();
        send_flag(); send_flag(); send_flag();
        send_bytes(48'h0000_6745_2301, 4);
        send_flag();
        send_bytes(48'h0010_EFCD_AB89, 5);
        send_flag();
        idle(2);
        chk("shared sof", n_sof, 2);
        chk("shared eof", n_eof, 2);
        chk("shared len0", (got_len.size() > 0) ? got_len[0] : -1, 4);
        chk("shared len1", (got_len.size() > 1) ? got_len[1] : -1, 5);
        chk("shared err", (got_err.size() > 1) ? got_err[0] + got_err[1] : -1, 0);
        chk("shared nbytes", got_bytes.size(), 9);
        chk("shared byte4", (got_bytes.size() > 4) ? int'(got_bytes[4]) : -1, 'h89);

        // Receiver disabled mid-frame, with strobes presented while disabled
        clr_mon();
        send_flag();
        send_bytes(48'h0000_0000_3412, 2);
        rxen_i = 1'b0;
        rx_bit_en_i = 1'b1;
        rx_i = 1'b0;
        idle(3);
        rx_bit_en_i = 1'b0;
        rxen_i = 1'b1;
        idle(2);
        chk("rxen abort", n_abort, 1);
        chk("rxen eof", n_eof, 0);
        chk("rxen active", int'(active_o), 0);
        chk("rxen nbytes", got_bytes.size(), 1);
        clr_mon();
        send_frame(48'h0000_4433_2211, 4);
        check_frame("post_rxen", 48'h0000_4433_2211, 4, 1, 4, 0);

        // Reset mid-frame clears every output with no abort or eof
        clr_mon();
        send_flag();
        send_bytes(48'h0000_00EF_CDAB, 3);
        chk("rst active_mid", int'(active_o), 1);
        rst_n_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_mid outputs", int'({byte_o, frame_len_o, byte_valid_o, sof_o, eof_o,
                                     frame_err_o, abort_o, active_o}), 0);
        @(posedge clk_i); #1;
        rst_n_i = 1'b1;
        ones_tx = 0;
        idle(2);
        chk("rst abort", n_abort, 0);
        chk("rst eof", n_eof, 0);
        chk("rst nbytes", got_bytes.size(), 2);
        clr_mon();
        send_frame(48'h0000_A1B2_C3D4, 4);
        check_frame("post_rst", 48'h0000_A1B2_C3D4, 4, 1, 4, 0);

        // 256 octets: byte count saturates at 255 and flags an error
        clr_mon();
        send_flag();
        for (int i = 0; i < 256; i++) send_byte(8'h00);
        send_flag();
        idle(2);
        chk("sat nbytes", got_bytes.size(), 256);
        chk("sat eof", n_eof, 1);
        chk("sat len", (got_len.size() > 0) ? got_len[0] : -1, 255);
        chk("sat err", (got_err.size() > 0) ? got_err[0] : -1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
